// File: rtl/branch_pkg.sv
// Shared constants and helpers for the branch predictor / resolver.
// Conditional-branch encodings, BHT states and table geometry.
package branch_pkg;

  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b010;
  localparam logic [2:0] BR_BGE  = 3'b011;
  localparam logic [2:0] BR_BLTU = 3'b100;
  localparam logic [2:0] BR_BGEU = 3'b101;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  function automatic int idx_w(input int entries);
    return $clog2(entries);
  endfunction

  function automatic int tag_w(input int xlen, input int entries);
    return xlen - $clog2(entries) - 2;
  endfunction

endpackage

// File: rtl/branch_predict_resolve_cond.sv
// Conditional-branch comparator for the six RV32I branch types.
// Unknown encodings are flagged illegal and resolve not-taken.
module branch_cond
  import branch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_op_a,
  input  logic [XLEN-1:0] i_op_b,
  input  logic [2:0]      i_ctrl,
  output logic            o_taken,
  output logic            o_illegal
);

  logic w_eq;
  logic w_lt;
  logic w_ltu;

  assign w_eq  = (i_op_a == i_op_b);
  assign w_lt  = ($signed(i_op_a) < $signed(i_op_b));
  assign w_ltu = (i_op_a < i_op_b);

  always_comb begin
    o_taken   = 1'b0;
    o_illegal = 1'b0;
    unique case (i_ctrl)
      BR_BEQ:  o_taken = w_eq;
      BR_BNE:  o_taken = ~w_eq;
      BR_BLT:  o_taken = w_lt;
      BR_BGE:  o_taken = ~w_lt;
      BR_BLTU: o_taken = w_ltu;
      BR_BGEU: o_taken = ~w_ltu;
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_predict_resolve.sv
// Fetch-side BHT/BTB predictor plus execute-side branch resolver,
// registered redirect, table training and saturating perf counters.
module branch_predict_resolve
  import branch_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 64,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  f_pc,
  output logic             f_pred_taken,
  output logic [XLEN-1:0]  f_pred_target,
  input  logic             ex_valid,
  input  logic             ex_branch,
  input  logic             ex_jal,
  input  logic             ex_jalr,
  input  logic [2:0]       ex_branch_ctrl,
  input  logic [XLEN-1:0]  ex_op_a,
  input  logic [XLEN-1:0]  ex_op_b,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [XLEN-1:0]  ex_imm,
  input  logic             ex_pred_taken,
  input  logic [XLEN-1:0]  ex_pred_target,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             illegal_ctrl,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispredict_cnt
);

  localparam int IDX_W = idx_w(ENTRIES);
  localparam int TAG_W = tag_w(XLEN, ENTRIES);

  logic [1:0]       r_bht     [ENTRIES];
  logic [ENTRIES-1:0] r_btb_v;
  logic [TAG_W-1:0] r_btb_tag [ENTRIES];
  logic [XLEN-1:0]  r_btb_tgt [ENTRIES];

  logic             r_redirect_valid;
  logic [XLEN-1:0]  r_redirect_pc;
  logic             r_illegal;
  logic [CNT_W-1:0] r_branch_cnt;
  logic [CNT_W-1:0] r_mispredict_cnt;

  logic [IDX_W-1:0] w_f_idx;
  logic [TAG_W-1:0] w_f_tag;
  logic [IDX_W-1:0] w_ex_idx;
  logic [TAG_W-1:0] w_ex_tag;
  logic             w_cond_taken;
  logic             w_cond_illegal;
  logic             w_active;
  logic             w_illegal_br;
  logic             w_legal;
  logic             w_taken;
  logic [XLEN-1:0]  w_target;
  logic [XLEN-1:0]  w_br_tgt;
  logic [XLEN-1:0]  w_jalr_sum;
  logic             w_mispredict;
  logic [1:0]       w_bht_cur;
  logic [1:0]       w_bht_nxt;

  assign w_f_idx  = f_pc[IDX_W+1:2];
  assign w_f_tag  = f_pc[XLEN-1:IDX_W+2];
  assign w_ex_idx = ex_pc[IDX_W+1:2];
  assign w_ex_tag = ex_pc[XLEN-1:IDX_W+2];

  assign f_pred_taken  = r_btb_v[w_f_idx]
                       & (r_btb_tag[w_f_idx] == w_f_tag)
                       & r_bht[w_f_idx][1];
  assign f_pred_target = f_pred_taken ? r_btb_tgt[w_f_idx]
                                      : f_pc + XLEN'(4);

  branch_cond #(.XLEN(XLEN)) u_cond (
    .i_op_a    (ex_op_a),
    .i_op_b    (ex_op_b),
    .i_ctrl    (ex_branch_ctrl),
    .o_taken   (w_cond_taken),
    .o_illegal (w_cond_illegal)
  );

  // the slot right after a redirect is a wrong-path instruction
  assign w_active = ex_valid & ~r_redirect_valid
                  & (ex_branch | ex_jal | ex_jalr);
  assign w_illegal_br = ex_branch & w_cond_illegal;
  assign w_legal      = w_active & ~w_illegal_br;

  assign w_br_tgt   = ex_pc + ex_imm;
  assign w_jalr_sum = ex_op_a + ex_imm;

  always_comb begin
    w_taken  = 1'b0;
    w_target = w_br_tgt;
    unique case (1'b1)
      ex_jalr: begin
        w_taken  = 1'b1;
        w_target = {w_jalr_sum[XLEN-1:1], 1'b0};
      end
      ex_jal:    w_taken = 1'b1;
      ex_branch: w_taken = w_cond_taken;
      default: ;
    endcase
  end

  assign w_mispredict = (w_taken != ex_pred_taken)
                      | (w_taken & (w_target != ex_pred_target));

  assign w_bht_cur = r_bht[w_ex_idx];

  always_comb begin
    w_bht_nxt = ST;
    if (ex_branch) begin
      if (w_taken)
        w_bht_nxt = (w_bht_cur == ST) ? ST : w_bht_cur + 2'd1;
      else
        w_bht_nxt = (w_bht_cur == SNT) ? SNT : w_bht_cur - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
      r_illegal        <= 1'b0;
      r_branch_cnt     <= '0;
      r_mispredict_cnt <= '0;
    end else begin
      r_redirect_valid <= w_active & w_mispredict;
      r_illegal        <= w_active & w_illegal_br;
      if (w_active) begin
        r_redirect_pc <= w_taken ? w_target : ex_pc + XLEN'(4);
        if (~&r_branch_cnt)
          r_branch_cnt <= r_branch_cnt + CNT_W'(1);
        if (w_mispredict && ~&r_mispredict_cnt)
          r_mispredict_cnt <= r_mispredict_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++)
        r_bht[i] <= WNT;
      r_btb_v <= '0;
    end else if (w_legal) begin
      r_bht[w_ex_idx] <= w_bht_nxt;
      if (w_taken)
        r_btb_v[w_ex_idx] <= 1'b1;
    end
  end

  // tags and targets are qualified by r_btb_v, so no reset needed
  always_ff @(posedge clk) begin
    if (!rst && w_legal && w_taken) begin
      r_btb_tag[w_ex_idx] <= w_ex_tag;
      r_btb_tgt[w_ex_idx] <= w_target;
    end
  end

  assign redirect_valid = r_redirect_valid;
  assign redirect_pc    = r_redirect_pc;
  assign illegal_ctrl   = r_illegal;
  assign branch_cnt     = r_branch_cnt;
  assign mispredict_cnt = r_mispredict_cnt;

endmodule

// File: tb/tb_branch_predict_resolve.sv
// Randomised + directed bench for branch_predict_resolve against
// a table-level behavioural model of predictor and resolver.
module tb_branch_predict_resolve;

  localparam int XLEN    = 32;
  localparam int ENTRIES = 16;
  localparam int CNT_W   = 4;
  localparam int IW      = 4;
  localparam int CMAX    = 15;

  logic             clk = 1'b0;
  logic             rst;
  logic [XLEN-1:0]  f_pc;
  logic             f_pred_taken;
  logic [XLEN-1:0]  f_pred_target;
  logic             ex_valid;
  logic             ex_branch;
  logic             ex_jal;
  logic             ex_jalr;
  logic [2:0]       ex_branch_ctrl;
  logic [XLEN-1:0]  ex_op_a;
  logic [XLEN-1:0]  ex_op_b;
  logic [XLEN-1:0]  ex_pc;
  logic [XLEN-1:0]  ex_imm;
  logic             ex_pred_taken;
  logic [XLEN-1:0]  ex_pred_target;
  logic             redirect_valid;
  logic [XLEN-1:0]  redirect_pc;
  logic             illegal_ctrl;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispredict_cnt;

  branch_predict_resolve #(
    .XLEN(XLEN), .ENTRIES(ENTRIES), .CNT_W(CNT_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .f_pc           (f_pc),
    .f_pred_taken   (f_pred_taken),
    .f_pred_target  (f_pred_target),
    .ex_valid       (ex_valid),
    .ex_branch      (ex_branch),
    .ex_jal         (ex_jal),
    .ex_jalr        (ex_jalr),
    .ex_branch_ctrl (ex_branch_ctrl),
    .ex_op_a        (ex_op_a),
    .ex_op_b        (ex_op_b),
    .ex_pc          (ex_pc),
    .ex_imm         (ex_imm),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_target (ex_pred_target),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .illegal_ctrl   (illegal_ctrl),
    .branch_cnt     (branch_cnt),
    .mispredict_cnt (mispredict_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int          mbht [ENTRIES];
  bit          mv   [ENTRIES];
  logic [31:0] mpc  [ENTRIES];
  logic [31:0] mtgt [ENTRIES];
  bit          m_rv;
  logic [31:0] m_rpc;
  bit          m_rpc_chk;
  bit          m_ill;
  int          m_bcnt;
  int          m_mcnt;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  function automatic int ix(input logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  // BTB hit = same entry written by a PC sharing the upper tag bits
  function automatic bit m_pred(input logic [31:0] pc);
    int i = ix(pc);
    return mv[i] && ((mpc[i] >> (IW + 2)) == (pc >> (IW + 2)))
           && (mbht[i] >= 2);
  endfunction

  function automatic logic [31:0] m_ptgt(input logic [31:0] pc);
    return m_pred(pc) ? mtgt[ix(pc)] : pc + 32'd4;
  endfunction

  task automatic model_update();
    bit act, tk, ill, misp;
    logic [31:0] tgt;
    int i;
    if (rst) begin
      for (int k = 0; k < ENTRIES; k++) begin
        mbht[k] = 1;
        mv[k]   = 0;
      end
      m_rv = 0; m_rpc = 0; m_rpc_chk = 1; m_ill = 0;
      m_bcnt = 0; m_mcnt = 0;
      return;
    end
    act = ex_valid && !m_rv && (ex_branch || ex_jal || ex_jalr);
    if (!act) begin
      m_rv = 0; m_ill = 0; m_rpc_chk = 0;
      return;
    end
    tk = 0; ill = 0;
    tgt = ex_pc + ex_imm;
    if (ex_branch) begin
      case (ex_branch_ctrl)
        3'd0: tk = (ex_op_a == ex_op_b);
        3'd1: tk = (ex_op_a != ex_op_b);
        3'd2: tk = ($signed(ex_op_a) < $signed(ex_op_b));
        3'd3: tk = ($signed(ex_op_a) >= $signed(ex_op_b));
        3'd4: tk = (ex_op_a < ex_op_b);
        3'd5: tk = (ex_op_a >= ex_op_b);
        default: ill = 1;
      endcase
    end else if (ex_jal) begin
      tk = 1;
    end else begin
      tk = 1;
      tgt = (ex_op_a + ex_imm) & 32'hFFFF_FFFE;
    end
    misp = (tk != ex_pred_taken) || (tk && tgt != ex_pred_target);
    m_bcnt = (m_bcnt >= CMAX) ? CMAX : m_bcnt + 1;
    if (misp) m_mcnt = (m_mcnt >= CMAX) ? CMAX : m_mcnt + 1;
    if (!ill) begin
      i = ix(ex_pc);
      if (ex_branch)
        mbht[i] = tk ? ((mbht[i] == 3) ? 3 : mbht[i] + 1)
                     : ((mbht[i] == 0) ? 0 : mbht[i] - 1);
      else
        mbht[i] = 3;
      if (tk) begin
        mv[i] = 1; mpc[i] = ex_pc; mtgt[i] = tgt;
      end
    end
    m_rv = misp;
    m_rpc = tk ? tgt : ex_pc + 32'd4;
    m_rpc_chk = 1;
    m_ill = ill;
  endtask

  task automatic check_reg();
    chk("redirect_valid", 32'(redirect_valid), 32'(m_rv));
    chk("illegal_ctrl", 32'(illegal_ctrl), 32'(m_ill));
    chk("branch_cnt", 32'(branch_cnt), 32'(m_bcnt));
    chk("mispredict_cnt", 32'(mispredict_cnt), 32'(m_mcnt));
    if (m_rpc_chk) chk("redirect_pc", redirect_pc, m_rpc);
  endtask

  task automatic check_comb();
    chk("f_pred_taken", 32'(f_pred_taken), 32'(m_pred(f_pc)));
    chk("f_pred_target", f_pred_target, m_ptgt(f_pc));
  endtask

  // inputs are already driven; check prediction, clock, check outputs
  task automatic tick();
    #1 check_comb();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_reg();
  endtask

  task automatic idle();
    ex_valid = 0; ex_branch = 0; ex_jal = 0; ex_jalr = 0;
    ex_branch_ctrl = 0; ex_op_a = 0; ex_op_b = 0; ex_pc = 0;
    ex_imm = 0; ex_pred_taken = 0; ex_pred_target = 0;
  endtask

  task automatic ex(input int cls, input logic [2:0] ctrl,
                    input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] pc, input logic [31:0] imm,
                    input logic pt, input logic [31:0] ptgt);
    ex_valid = 1;
    ex_branch = (cls == 1); ex_jal = (cls == 2); ex_jalr = (cls == 3);
    ex_branch_ctrl = ctrl; ex_op_a = a; ex_op_b = b;
    ex_pc = pc; ex_imm = imm;
    ex_pred_taken = pt; ex_pred_target = ptgt;
  endtask

  initial begin
    logic [31:0] pc, a, b, imm;
    int cls;
    rst = 1; f_pc = 32'h100; idle();
    @(negedge clk);
    tick(); tick();
    chk("rst_rv", 32'(redirect_valid), 0);
    chk("rst_rpc", redirect_pc, 0);
    chk("rst_bcnt", 32'(branch_cnt), 0);
    rst = 0;
    #1 chk("lit_pred0", 32'(f_pred_taken), 0);
    chk("lit_ptgt0", f_pred_target, 32'h104);

    ex(1, 3'd0, 5, 5, 32'h100, 32'h40, 0, 0); tick();
    chk("lit_beq_rv", 32'(redirect_valid), 1);
    chk("lit_beq_rpc", redirect_pc, 32'h140);
    chk("lit_beq_mc", 32'(mispredict_cnt), 1);
    ex(1, 3'd1, 1, 2, 32'h100, 32'h40, 0, 0); tick();
    chk("lit_squash_rv", 32'(redirect_valid), 0);
    chk("lit_squash_bc", 32'(branch_cnt), 1);
    chk("lit_squash_mc", 32'(mispredict_cnt), 1);

    ex(1, 3'd0, 5, 5, 32'h100, 32'h40, 1, 32'h140); tick();
    chk("lit_beq2_rv", 32'(redirect_valid), 0);
    ex(1, 3'd0, 5, 5, 32'h100, 32'h40, 1, 32'h140); tick();
    chk("lit_beq3_rv", 32'(redirect_valid), 0);
    idle();
    #1 chk("lit_pred1", 32'(f_pred_taken), 1);
    chk("lit_ptgt1", f_pred_target, 32'h140);

    ex(1, 3'd2, 32'hFFFF_FFFF, 1, 32'h200, 32'h10, 0, 0); tick();
    chk("lit_blt_rpc", redirect_pc, 32'h210);
    idle(); tick();
    ex(1, 3'd4, 32'hFFFF_FFFF, 1, 32'h200, 32'h10, 1, 32'h210); tick();
    chk("lit_bltu_rv", 32'(redirect_valid), 1);
    chk("lit_bltu_rpc", redirect_pc, 32'h204);
    idle(); tick();

    ex(3, 3'd0, 32'h2003, 0, 32'h300, 4, 0, 0); tick();
    chk("lit_jalr_rpc", redirect_pc, 32'h2006);
    idle(); tick();
    f_pc = 32'h300;
    #1 chk("lit_jalr_pred", 32'(f_pred_taken), 1);
    chk("lit_jalr_ptgt", f_pred_target, 32'h2006);

    ex(1, 3'd7, 0, 0, 32'h400, 8, 0, 0); tick();
    chk("lit_ill", 32'(illegal_ctrl), 1);
    chk("lit_ill_rv", 32'(redirect_valid), 0);
    idle(); tick();
    chk("lit_ill_off", 32'(illegal_ctrl), 0);

    ex(2, 3'd0, 0, 0, 32'h500, 32'h20, 0, 0);
    rst = 1; tick(); rst = 0;
    chk("lit_mrst_rv", 32'(redirect_valid), 0);
    chk("lit_mrst_bc", 32'(branch_cnt), 0);
    chk("lit_mrst_rpc", redirect_pc, 0);
    idle();
    #1 chk("lit_mrst_pred", 32'(f_pred_taken), 0);

    for (int i = 0; i < 16; i++) begin
      ex(1, 3'd0, 1, 2, 32'h600, 4, 0, 0); tick();
      if (i >= 14) chk("lit_sat_bc", 32'(branch_cnt), 15);
    end
    chk("lit_sat_mc", 32'(mispredict_cnt), 0);

    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 249) == 0);
      pc = 32'h1000 + ($urandom_range(0, 3) << 6)
         + ($urandom_range(0, 15) << 2);
      a = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 3);
      b = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 3);
      imm = 32'($urandom_range(0, 63) * 4) - 32'd128;
      cls = $urandom_range(0, 3);
      ex(cls, 3'($urandom_range(0, 7)), a, b, pc, imm, 0, 0);
      if ($urandom_range(0, 3) == 0) begin
        ex_pred_taken = 1'($urandom);
        ex_pred_target = $urandom_range(0, 1) ? $urandom : pc + imm;
      end else begin
        ex_pred_taken = m_pred(pc);
        ex_pred_target = m_ptgt(pc);
      end
      if (cls == 0 || $urandom_range(0, 4) == 0) ex_valid = 0;
      if (cls == 0) ex_valid = $urandom_range(0, 1) == 1;
      f_pc = 32'h1000 + ($urandom_range(0, 3) << 6)
           + ($urandom_range(0, 15) << 2);
      tick();
    end
    rst = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_predict_resolve.md
# branch_predict_resolve

Parametrised successor to the combinational branch unit. It combines a fetch-stage predictor with an execute-stage resolver. The predictor is a direct-mapped branch history table (BHT) of 2-bit saturating counters plus a tagged branch target buffer (BTB). The resolver evaluates all RV32I conditional branches, JAL and JALR, detects mispredictions, issues a registered redirect/flush to fetch, trains the tables and keeps saturating performance counters.

## Interface
- XLEN, 32, data/address width
- ENTRIES, 64, BHT/BTB depth; power of two, ≥2; IDX_W = log2(ENTRIES)
- CNT_W, 32, width of performance counters
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- f_pc  in  XLEN  fetch PC
- f_pred_taken  out  1  combinational prediction for f_pc
- f_pred_target  out  XLEN  predicted target; equals f_pc+4 when not predicted taken
- ex_valid  in  1  execute-stage instruction valid
- ex_branch, ex_jal, ex_jalr  in  1 each  instruction class, one-hot or all zero
- ex_branch_ctrl  in  3  000 BEQ, 001 BNE, 010 BLT, 011 BGE, 100 BLTU, 101 BGEU
- ex_op_a, ex_op_b, ex_pc, ex_imm  in  XLEN  operands, instruction PC, sign-extended immediate
- ex_pred_taken, ex_pred_target  in  1, XLEN  prediction carried down the pipe with the instruction
- redirect_valid  out  1  registered flush/redirect pulse
- redirect_pc  out  XLEN  registered correct next PC
- illegal_ctrl  out  1  registered; ex_branch with ex_branch_ctrl 110/111
- branch_cnt, mispredict_cnt  out  CNT_W  saturating counts of resolved control-flow instructions and of mispredictions

## Operation
- Indexing:
  - idx = pc[IDX_W+1:2]
  - tag = pc[XLEN-1:IDX_W+2]
- Predict: f_pred_taken = btb_valid[idx] & (btb_tag[idx]==tag) & bht[idx][1]. f_pred_target = btb_target[idx] when taken, else f_pc+4.
- An instruction is active when ex_valid=1, redirect_valid=0 and at least one class bit is set. When redirect_valid=1, the execute slot holds a wrong-path instruction and is ignored completely: no training, no counting, no redirect.
- Resolve for an active instruction:
  - Branch: taken per ctrl, with equality computed internally (no zero-flag input). Target = ex_pc+ex_imm.
  - JAL: always taken; target = ex_pc+ex_imm.
  - JALR: always taken; target = (ex_op_a+ex_imm) & ~1.
  - Ctrl 110/111: not taken, no training, illegal_ctrl=1 next cycle; still counted in branch_cnt.
  - All additions wrap modulo 2^XLEN.
- Mispredict = (taken != ex_pred_taken) | (taken & target != ex_pred_target).
- Next cycle: redirect_valid = mispredict; redirect_pc = taken ? target : ex_pc+4.
- Training, applied at the clock edge for legal active instructions:
  - Branch: bht[idx] saturating +1 if taken, −1 if not (00↔11 bounds).
  - Jump: bht[idx] = 11.
  - Any taken instruction: write btb valid, tag and target. A not-taken branch leaves the BTB unchanged.
- branch_cnt increments on each active instruction. mispredict_cnt increments on each mispredict. Both hold at all-ones.

## Timing
- Prediction is purely combinational from f_pc and the table state. Training is read-before-write: a lookup at the same idx in the update cycle sees the old contents.
- Resolve latency is 1 cycle: outputs are registered from the ex_* inputs sampled at edge N and are visible after edge N.
- redirect_valid is a single-cycle pulse per mispredict. Two back-to-back active mispredicts are impossible, because the second slot is squashed.
- Reset (takes priority, also mid-operation):
  - Outputs: redirect_valid=0, redirect_pc=0, illegal_ctrl=0, branch_cnt=0, mispredict_cnt=0.
  - Tables: all BHT entries = 01 (weakly not-taken), all BTB valid = 0. Tags and targets need not reset.
  - Inputs presented during reset are ignored.
- No stall input: the pipeline must hold ex_valid low rather than repeat an instruction.

## Structure
- Shared package `branch_pkg`:
  - branch_ctrl localparams (BEQ…BGEU)
  - BHT state constants: SNT=00, WNT=01, WT=10, ST=11
  - Default IDX/tag width functions
- Sub-module `branch_cond` (combinational comparator: op_a, op_b, ctrl → taken, illegal) is instantiated once. The tables, training, registers and counters live in the top.

## Test plan
- After reset, f_pc=0x100 → f_pred_taken=0, f_pred_target=0x104. BEQ at 0x100 with a=b=5, imm=0x40, pred 0 → next cycle redirect_valid=1, redirect_pc=0x140, mispredict_cnt=1.
- Same BEQ resolved taken twice more → bht=11, BTB valid. f_pc=0x100 → taken, target 0x140. Resolve with pred 1/0x140 → no redirect.
- BLT a=0xFFFFFFFF, b=1 → taken. BLTU with the same operands → not taken; redirect_pc=pc+4 when predicted taken.
- JALR a=0x2003, imm=4, pred 0 → redirect_pc=0x2006 and bht=11. Active mispredict followed by an ex_valid=1 BNE in the next cycle → BNE ignored: counters, tables and redirect unchanged.
- ex_branch_ctrl=111 → illegal_ctrl pulses, not taken, bht unchanged. Assert rst mid-stream → all outputs 0 and the next lookup predicts not-taken.
- Force branch_cnt to all-ones (CNT_W=4 build: 15 resolves) → 16th resolve keeps branch_cnt=15.
